// File: rtl/operand_entry_controller_if.sv
// rtl/operand_entry_controller_if.sv - board I/O and processinho strobe bundle for operand_entry_controller
interface operand_entry_controller_if;
   logic [3:0] switches;
   logic       key_enter;
   logic       key_clear;
   logic [3:0] operando;
   logic       setRegA;
   logic       setRegB;
   logic [3:0] ula_operation;
   logic       latch_ula;
   logic [2:0] phase;
   logic       busy;

   modport master (
      input  switches, key_enter, key_clear,
      output operando, setRegA, setRegB, ula_operation, latch_ula, phase, busy
   );

   modport slave (
      output switches, key_enter, key_clear,
      input  operando, setRegA, setRegB, ula_operation, latch_ula, phase, busy
   );
endinterface

// File: rtl/operand_entry_controller.sv
// rtl/operand_entry_controller.sv - debounced button sequencer capturing A, B and opcode for processinho
module operand_entry_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clock,
   input  logic reset,
   input  logic key_n,
   output logic press_evt
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1, sync2, stable, stable_prev;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         stable      <= 1'b0;
         stable_prev <= 1'b0;
         cnt         <= '0;
      end else begin
         sync1       <= ~key_n;
         sync2       <= sync1;
         stable_prev <= stable;
         // Any sample agreeing with the stable level restarts the count.
         if (sync2 != stable) begin
            if (cnt == CNT_LAST) begin
               stable <= sync2;
               cnt    <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign press_evt = stable & ~stable_prev;
endmodule

module operand_entry_controller #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic                        clock,
   input  logic                        reset,
   operand_entry_controller_if.master  bus
);
   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      SHOW    = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] operando_q, operando_d;
   logic [3:0] ula_q, ula_d;
   logic       set_a_q, set_a_d;
   logic       set_b_q, set_b_d;
   logic       latch_q, latch_d;
   logic       enter_evt, clear_evt;

   operand_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_enter (
      .clock     (clock),
      .reset     (reset),
      .key_n     (bus.key_enter),
      .press_evt (enter_evt)
   );

   operand_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clear (
      .clock     (clock),
      .reset     (reset),
      .key_n     (bus.key_clear),
      .press_evt (clear_evt)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= WAIT_A;
         operando_q <= 4'h0;
         ula_q      <= 4'h0;
         set_a_q    <= 1'b0;
         set_b_q    <= 1'b0;
         latch_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         operando_q <= operando_d;
         ula_q      <= ula_d;
         set_a_q    <= set_a_d;
         set_b_q    <= set_b_d;
         latch_q    <= latch_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      operando_d = operando_q;
      ula_d      = ula_q;
      set_a_d    = 1'b0;
      set_b_d    = 1'b0;
      latch_d    = 1'b0;
      // Clear dominates enter; an EXEC cycle still fires its latch.
      if (clear_evt) begin
         state_d = WAIT_A;
         latch_d = (state_q == EXEC);
      end else begin
         case (state_q)
            WAIT_A: if (enter_evt) begin
               operando_d = bus.switches;
               set_a_d    = 1'b1;
               state_d    = WAIT_B;
            end
            WAIT_B: if (enter_evt) begin
               operando_d = bus.switches;
               set_b_d    = 1'b1;
               state_d    = WAIT_OP;
            end
            WAIT_OP: if (enter_evt) begin
               ula_d   = bus.switches;
               state_d = EXEC;
            end
            EXEC: begin
               latch_d = 1'b1;
               state_d = SHOW;
            end
            SHOW: if (enter_evt) begin
               state_d = WAIT_A;
            end
            default: state_d = WAIT_A;
         endcase
      end
   end

   assign bus.operando      = operando_q;
   assign bus.ula_operation = ula_q;
   assign bus.setRegA       = set_a_q;
   assign bus.setRegB       = set_b_q;
   assign bus.latch_ula     = latch_q;
   assign bus.phase         = state_q;
   assign bus.busy          = (state_q != WAIT_A);
endmodule

// File: tb/tb_operand_entry_controller.sv
// tb/tb_operand_entry_controller.sv - self-checking bench for operand_entry_controller
module tb_operand_entry_controller;
   localparam int D = 4;

   typedef struct {
      logic [3:0] sw;
      logic       enter;
      logic       clear;
      int         strobe;
      logic [3:0] exp_op;
      logic [3:0] exp_ula;
      logic [2:0] exp_phase;
   } vec_t;

   typedef struct {
      int         kind;
      logic [3:0] val;
   } sb_t;

   logic clock;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   sb_t  sb_q[$];
   vec_t vecs[10];

   operand_entry_controller_if bus();

   operand_entry_controller #(.DEBOUNCE_CYCLES(D)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic sb_check(input int kind, input logic [3:0] val, input string name);
      sb_t e;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s unexpected strobe: got value %0h, required no strobe", name, val);
      end else begin
         e = sb_q.pop_front();
         if (e.kind != kind || e.val !== val) begin
            n_fail++;
            $display("FAIL %s: got kind %0d value %0h, required kind %0d value %0h",
                     name, kind, val, e.kind, e.val);
         end
      end
   endtask

   task automatic push_exp(input int kind, input logic [3:0] val);
      sb_t e;
      e.kind = kind;
      e.val  = val;
      sb_q.push_back(e);
   endtask

   always @(negedge clock) begin
      if (reset === 1'b1) begin
         if (bus.setRegA)   sb_check(1, bus.operando, "setRegA");
         if (bus.setRegB)   sb_check(2, bus.operando, "setRegB");
         if (bus.latch_ula) sb_check(3, bus.ula_operation, "latch_ula");
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic press(input logic e, input logic c, input int hold);
      bus.key_enter = ~e;
      bus.key_clear = ~c;
      wait_cyc(hold);
      bus.key_enter = 1'b1;
      bus.key_clear = 1'b1;
      wait_cyc(12);
   endtask

   task automatic check_outputs(input string tag, input logic [3:0] op, input logic [3:0] ula,
                                input logic [2:0] ph);
      check({tag, " operando"}, 32'(bus.operando), 32'(op));
      check({tag, " ula_operation"}, 32'(bus.ula_operation), 32'(ula));
      check({tag, " phase"}, 32'(bus.phase), 32'(ph));
      check({tag, " busy"}, 32'(bus.busy), 32'(ph != 3'd0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_seen;
      int highs;
      bit seen;

      vecs[0] = '{4'h0, 1'b0, 1'b1, 0, 4'h5, 4'h0, 3'd0};
      vecs[1] = '{4'h3, 1'b1, 1'b0, 1, 4'h3, 4'h0, 3'd1};
      vecs[2] = '{4'h9, 1'b1, 1'b0, 2, 4'h9, 4'h0, 3'd2};
      vecs[3] = '{4'h2, 1'b1, 1'b0, 3, 4'h9, 4'h2, 3'd4};
      vecs[4] = '{4'h7, 1'b1, 1'b0, 0, 4'h9, 4'h2, 3'd0};
      vecs[5] = '{4'ha, 1'b1, 1'b0, 1, 4'ha, 4'h2, 3'd1};
      vecs[6] = '{4'hc, 1'b1, 1'b1, 0, 4'ha, 4'h2, 3'd0};
      vecs[7] = '{4'h6, 1'b1, 1'b0, 1, 4'h6, 4'h2, 3'd1};
      vecs[8] = '{4'h1, 1'b1, 1'b0, 2, 4'h1, 4'h2, 3'd2};
      vecs[9] = '{4'hf, 1'b0, 1'b1, 0, 4'h1, 4'h2, 3'd0};

      reset         = 1'b1;
      bus.switches  = 4'h0;
      bus.key_enter = 1'b1;
      bus.key_clear = 1'b1;
      #2 reset = 1'b0;
      #1;
      check_outputs("reset", 4'h0, 4'h0, 3'd0);
      check("reset strobes", 32'({bus.setRegA, bus.setRegB, bus.latch_ula}), 32'd0);
      wait_cyc(2);
      reset = 1'b1;
      wait_cyc(20);
      check_outputs("idle", 4'h0, 4'h0, 3'd0);
      check("idle strobes", 32'({bus.setRegA, bus.setRegB, bus.latch_ula}), 32'd0);

      // First strobe lands on the 7th edge after the press is first sampled.
      bus.switches = 4'h5;
      push_exp(1, 4'h5);
      bus.key_enter = 1'b0;
      first_seen = 0;
      highs      = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         if (bus.setRegA) begin
            highs++;
            if (first_seen == 0) first_seen = k;
         end
      end
      check("setRegA edge", 32'(first_seen), 32'd7);
      check("setRegA width", 32'(highs), 32'd1);
      bus.key_enter = 1'b1;
      wait_cyc(12);
      check_outputs("clean press", 4'h5, 4'h0, 3'd1);

      for (int i = 0; i < 10; i++) begin
         bus.switches = vecs[i].sw;
         if (vecs[i].strobe == 3) push_exp(3, vecs[i].sw);
         else if (vecs[i].strobe != 0) push_exp(vecs[i].strobe, vecs[i].sw);
         press(vecs[i].enter, vecs[i].clear, 10);
         check_outputs($sformatf("vec%0d", i), vecs[i].exp_op, vecs[i].exp_ula, vecs[i].exp_phase);
      end

      // Bouncing press must yield exactly one capture.
      bus.switches = 4'h8;
      push_exp(1, 4'h8);
      bus.key_enter = 1'b0; wait_cyc(2);
      bus.key_enter = 1'b1; wait_cyc(1);
      bus.key_enter = 1'b0; wait_cyc(2);
      bus.key_enter = 1'b1; wait_cyc(1);
      check("bounce no early event", 32'(bus.phase), 32'd0);
      press(1'b1, 1'b0, 10);
      check_outputs("bounce", 4'h8, 4'h2, 3'd1);

      bus.switches = 4'hb;
      push_exp(2, 4'hb);
      bus.key_enter = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clock);
         if (bus.setRegB) seen = 1'b1;
      end
      check("setRegB seen before reset", 32'(seen), 32'd1);
      check("phase before reset", 32'(bus.phase), 32'd2);
      #1 reset = 1'b0;
      #1;
      check("setRegB drop on reset", 32'(bus.setRegB), 32'd0);
      check_outputs("mid reset", 4'h0, 4'h0, 3'd0);
      bus.key_enter = 1'b1;
      wait_cyc(3);
      reset = 1'b1;
      wait_cyc(10);
      check_outputs("after reset", 4'h0, 4'h0, 3'd0);

      bus.switches = 4'hd;
      push_exp(1, 4'hd);
      press(1'b1, 1'b0, 10);
      check_outputs("post reset A", 4'hd, 4'h0, 3'd1);

      check("scoreboard drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
